mem_access_ctrl: RTL and testbench

//   Data-memory access controller between the CPU MEM stage and a variable-latency data RAM.
//   - Accepts one load/store request per access and runs a valid/ready handshake on the memory side.
//   - Returns a one-cycle completion pulse with load data or an error flag.
//   - Lets the multi-cycle control unit stall in MEM until cpu_ready, instead of assuming 1-cycle memory.

---
 rtl/mem_access_ctrl_pkg.sv | 15 +
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared state encoding and constants for the data-memory access controller.
package mem_access_ctrl_pkg;

    localparam int unsigned MacStateLen = 2;

    typedef enum logic [MacStateLen-1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } mac_state_e;

    localparam int unsigned DefaultTimeoutCycles = 16;

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the CPU MEM stage and a variable-latency data RAM.
// Define MEM_ACCESS_TIMEOUT_EN to abort a bus access after TIMEOUT_CYCLES cycles without mem_ready.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    mac_state_e        state_q, state_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_valid_q, mem_valid_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_err_q, cpu_err_d;
    logic              timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter holds the number of BUS cycles already spent without mem_ready.
    always_comb begin
        cnt_d = '0;
        if (state_q == StBus && !mem_ready) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (cpu_addr[1:0] != 2'b00) begin
                        state_d = StErr;
                    end else begin
                        addr_d  = cpu_addr[ADDR_W-1:2];
                        we_d    = cpu_we;
                        wdata_d = cpu_wdata;
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end
            StDone, StErr: state_d = StIdle;
            default:       state_d = StIdle;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        mem_valid_d = (state_d == StBus);
        cpu_ready_d = (state_d == StDone) || (state_d == StErr);
        cpu_err_d   = (state_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_valid_q <= mem_valid_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized accesses against a
// transaction-level model. Expectations follow MEM_ACCESS_TIMEOUT_EN when it is defined.
module tb_mem_access_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic          cpu_err;
    logic [DW-1:0] cpu_rdata;
    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int rdy_count = 0;
    logic [DW-1:0] model_rdata = '0;

    mem_access_ctrl #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .cpu_err  (cpu_err),
        .cpu_rdata(cpu_rdata),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_valid && mem_ready) hs_count++;
        if (cpu_ready) rdy_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd0);
    endtask

    // One complete CPU access; wait_cycles = BUS cycles before mem_ready is raised.
    task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input int wait_cycles, input logic [DW-1:0] rd,
                             input logic pulse_req);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        mem_ready = 1'b0;
        step();
        cpu_req   = 1'b0;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_we    = $urandom_range(0, 1);
        if (addr[1:0] != 2'b00) begin
            chk("mis_valid", 32'(mem_valid), 32'd0);
            chk("mis_ready", 32'(cpu_ready), 32'd1);
            chk("mis_err", 32'(cpu_err), 32'd1);
            chk("mis_rdata", cpu_rdata, model_rdata);
            step();
            idle_outputs("mis_after");
            return;
        end
        for (int i = 0; i <= wait_cycles; i++) begin
            chk("bus_valid", 32'(mem_valid), 32'd1);
            chk("bus_we", 32'(mem_we), 32'(we));
            chk("bus_addr", mem_addr, {addr[AW-1:2], 2'b00});
            chk("bus_wdata", mem_wdata, wd);
            chk("bus_ready", 32'(cpu_ready), 32'd0);
            cpu_req   = pulse_req && (i == 0);
            mem_ready = (i == wait_cycles);
            mem_rdata = (i == wait_cycles) ? rd : DW'($urandom);
            step();
        end
        cpu_req   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (!we) model_rdata = rd;
        chk("done_ready", 32'(cpu_ready), 32'd1);
        chk("done_err", 32'(cpu_err), 32'd0);
        chk("done_valid", 32'(mem_valid), 32'd0);
        chk("done_rdata", cpu_rdata, model_rdata);
        step();
        idle_outputs("done_after");
    endtask

    initial begin
        int hs0;
        int rdy0;
        logic stuck_ok;

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_err", 32'(cpu_err), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        step();

        // Aligned load with zero wait, then store with three waits, then misaligned load
        do_access(1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
        do_access(1'b1, 32'h24, 32'h12345678, 3, 32'hA5A5A5A5, 1'b0);
        do_access(1'b0, 32'h13, 32'h0, 0, 32'h0, 1'b0);

        // cpu_req pulsed during BUS is ignored
        hs0  = hs_count;
        rdy0 = rdy_count;
        do_access(1'b0, 32'h40, 32'h0, 2, 32'hCAFEF00D, 1'b1);
        step();
        chk("pulse_hs", 32'(hs_count - hs0), 32'd1);
        chk("pulse_rdy", 32'(rdy_count - rdy0), 32'd1);
        idle_outputs("pulse_idle");

        // Reset asserted in the second BUS cycle
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h80;
        step();
        cpu_req = 1'b0;
        chk("rbus_valid1", 32'(mem_valid), 32'd1);
        step();
        chk("rbus_valid2", 32'(mem_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_rdata = '0;
        chk("rbus_valid", 32'(mem_valid), 32'd0);
        chk("rbus_ready", 32'(cpu_ready), 32'd0);
        chk("rbus_err", 32'(cpu_err), 32'd0);
        chk("rbus_rdata", cpu_rdata, 32'd0);
        chk("rbus_addr", mem_addr, 32'd0);
        chk("rbus_we", 32'(mem_we), 32'd0);
        step();
        do_access(1'b0, 32'h84, 32'h0, 1, 32'h0BADF00D, 1'b0);

        // mem_ready held low
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h100;
        mem_ready = 1'b0;
        step();
        cpu_req = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++) begin
            chk("to_valid", 32'(mem_valid), 32'd1);
            chk("to_ready", 32'(cpu_ready), 32'd0);
            step();
        end
        chk("to_end_valid", 32'(mem_valid), 32'd0);
        chk("to_end_ready", 32'(cpu_ready), 32'd1);
        chk("to_end_err", 32'(cpu_err), 32'd1);
        chk("to_end_rdata", cpu_rdata, model_rdata);
        step();
        idle_outputs("to_after");
`else
        stuck_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!mem_valid || cpu_ready) stuck_ok = 1'b0;
            step();
        end
        chk("stuck_waiting", 32'(stuck_ok), 32'd1);
        chk("stuck_valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h600DD00D;
        step();
        mem_ready = 1'b0;
        model_rdata = 32'h600DD00D;
        chk("stuck_done", 32'(cpu_ready), 32'd1);
        chk("stuck_rdata", cpu_rdata, model_rdata);
        step();
        idle_outputs("stuck_after");
`endif

        // Randomized accesses; waits stay within the timeout window so every access completes
        for (int n = 0; n < 25; n++) begin
            logic [AW-1:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_access(1'($urandom_range(0, 1)), a, DW'($urandom), int'($urandom_range(0, TO - 1)),
                      DW'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
